rd_fwft_out: RTL and testbench
==============================

RD_FWFT_OUT -- requirements
Module: rd_fwft_out

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data word width in bits.
REQ-002 SHALL have port i_RD_clk  input  1  read-domain clock; all state updates on rising edge.
REQ-003 SHALL have port i_RD_rst  input  1  reset; one clock, asynchronous, active-high.
REQ-004 SHALL have port i_Empty  input  1  registered empty flag from the read-pointer/empty stage.
REQ-005 SHALL have port o_RD_En  output  1  read request to the read-pointer/empty stage.
REQ-006 SHALL have port i_Mem_Data  input  WIDTH  FIFO memory read data, valid one cycle after a fetch edge.
REQ-007 SHALL have port o_Data  output  WIDTH  head-of-stream data word.
REQ-008 SHALL have port o_Valid  output  1  o_Data holds a valid word.
REQ-009 SHALL have port i_Ready  input  1  consumer accepts o_Data.
REQ-010 SHALL have port o_Level  output  2  words held in this stage, 0..2.
REQ-011 SHALL have port o_Err  output  1  sticky protocol-error flag.

Function
REQ-012 SHALL define fetch = o_RD_En & ~i_Empty at a rising edge; pop = o_Valid & i_Ready at a rising edge; arrive = registered in-flight flag r_Inflight.
REQ-013 SHALL set r_Inflight on the edge after each fetch and clear it otherwise: exactly one word per fetch, captured from i_Mem_Data at the next edge.
REQ-014 SHALL use a 2-entry buffer (head register driving o_Data, skid register) with occupancy FSM states EMPTY, ONE, TWO.
REQ-015 SHALL drive o_RD_En = ~i_RD_rst & ((occupancy + r_Inflight < 2) | pop); combinational path i_Ready -> o_RD_En permitted.
REQ-016 SHALL apply EMPTY transitions: arrive -> ONE, head <= i_Mem_Data; otherwise stay.
REQ-017 SHALL apply ONE transitions: arrive&pop -> ONE, head <= i_Mem_Data; arrive&~pop -> TWO, skid <= i_Mem_Data; ~arrive&pop -> EMPTY; none -> ONE.
REQ-018 SHALL apply TWO transitions: pop&arrive -> TWO, head <= skid, skid <= i_Mem_Data; pop&~arrive -> ONE, head <= skid; none -> TWO.
REQ-019 SHALL treat arrive&~pop in TWO as overflow: discard incoming word, stay TWO, set o_Err until reset.
REQ-020 SHALL drive o_Valid = (state != EMPTY) and o_Level = 0/1/2 for EMPTY/ONE/TWO, both from registers.
REQ-021 SHALL hold o_Data stable while o_Valid=1 and i_Ready=0.
REQ-022 SHALL deliver words in fetch order with no loss or duplication; fetch-to-o_Valid latency exactly 2 edges when the stage is empty.
REQ-023 SHALL sustain one word per cycle when i_Empty=0 and i_Ready=1 continuously.
REQ-024 SHALL ignore i_Mem_Data when r_Inflight=0.
REQ-025 SHALL, on i_Empty rising, issue no further fetches and drain held words normally; pop when EMPTY has no effect.

Reset
REQ-026 SHALL, while i_RD_rst=1, force state EMPTY, r_Inflight=0, head=0, skid=0, o_Err=0, hence o_Valid=0, o_Data=0, o_Level=0, o_RD_En=0, immediately and independent of clock.
REQ-027 SHALL discard buffered and in-flight words on reset mid-operation; first edge after release may fetch.

Verification
REQ-028 SHALL cover reset: i_RD_rst=1 with Level=2 mid-stream -> o_Valid=0, o_Data=0x00, o_Level=0, o_RD_En=0 before next edge.
REQ-029 SHALL cover single word: i_Empty=0 one cycle, i_Mem_Data=0xA5 next cycle -> o_Valid=1, o_Data=0xA5 after 2nd edge; pop -> o_Valid=0.
REQ-030 SHALL cover backpressure: i_Ready=0, i_Empty=0 for 4 cycles -> exactly 2 fetches, o_Level=2, o_RD_En=0, o_Data=first word stable.
REQ-031 SHALL cover streaming: i_Ready=1, words 0x01..0x10 continuously available -> 16 words in order, no bubbles after initial 2-cycle latency.
REQ-032 SHALL cover empty mid-stream: i_Empty rises after 3 fetches -> exactly 3 words delivered, o_Valid then 0, o_RD_En stays 1.
REQ-033 SHALL cover overflow injection: force arrive in TWO with i_Ready=0 -> o_Err=1 sticky, o_Data unchanged, o_Level=2.

Source files
------------

// File: rtl/rd_fwft_out.sv
// First-word-fall-through output stage for the read side of an async FIFO.
// Two-entry head/skid buffer fed by a one-cycle-latency memory read.
module rd_fwft_out #(
  parameter int WIDTH = 8
) (
  input  logic             i_RD_clk,
  input  logic             i_RD_rst,
  input  logic             i_Empty,
  output logic             o_RD_En,
  input  logic [WIDTH-1:0] i_Mem_Data,
  output logic [WIDTH-1:0] o_Data,
  output logic             o_Valid,
  input  logic             i_Ready,
  output logic [1:0]       o_Level,
  output logic             o_Err
);

  // encoding doubles as the occupancy count
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state;
  logic             r_Inflight;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] skid;
  logic             err;
  logic             pop;
  logic             fetch;
  logic [1:0]       pending;

  assign o_Valid = (state != EMPTY);
  assign o_Level = state;
  assign o_Data  = head;
  assign o_Err   = err;

  assign pop     = o_Valid & i_Ready;
  assign pending = o_Level + {1'b0, r_Inflight};
  assign o_RD_En = ~i_RD_rst & ((pending < 2'd2) | pop);
  assign fetch   = o_RD_En & ~i_Empty;

  always_ff @(posedge i_RD_clk or posedge i_RD_rst) begin
    if (i_RD_rst) begin
      state      <= EMPTY;
      r_Inflight <= 1'b0;
      head       <= '0;
      skid       <= '0;
      err        <= 1'b0;
    end else begin
      r_Inflight <= fetch;
      unique case (state)
        EMPTY: begin
          if (r_Inflight) begin
            state <= ONE;
            head  <= i_Mem_Data;
          end
        end
        ONE: begin
          if (r_Inflight && pop) begin
            head <= i_Mem_Data;
          end else if (r_Inflight) begin
            state <= TWO;
            skid  <= i_Mem_Data;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          if (pop && r_Inflight) begin
            head <= skid;
            skid <= i_Mem_Data;
          end else if (pop) begin
            state <= ONE;
            head  <= skid;
          end else if (r_Inflight) begin
            // no room: drop the word and flag it until reset
            err <= 1'b1;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_rd_fwft_out.sv
// Bench for rd_fwft_out: vector table, directed corner cases,
// and random traffic against a queue-based reference model.
module tb_rd_fwft_out;

  logic       clk = 1'b0;
  logic       i_RD_rst;
  logic       i_Empty;
  logic       o_RD_En;
  logic [7:0] i_Mem_Data;
  logic [7:0] o_Data;
  logic       o_Valid;
  logic       i_Ready;
  logic [1:0] o_Level;
  logic       o_Err;

  always #5 clk = ~clk;

  rd_fwft_out #(.WIDTH(8)) dut (
    .i_RD_clk  (clk),
    .i_RD_rst  (i_RD_rst),
    .i_Empty   (i_Empty),
    .o_RD_En   (o_RD_En),
    .i_Mem_Data(i_Mem_Data),
    .o_Data    (o_Data),
    .o_Valid   (o_Valid),
    .i_Ready   (i_Ready),
    .o_Level   (o_Level),
    .o_Err     (o_Err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // reference model: words held, one in-flight flag, stream counter
  logic [7:0] m_q[$];
  bit         m_inf;
  logic [7:0] seq;
  int         cyc;
  logic [7:0] got_w[$];
  int         got_c[$];

  task automatic step(input bit rst, input bit emp, input bit rdy);
    bit e_pop;
    bit e_en;
    @(negedge clk);
    i_RD_rst   = rst;
    i_Empty    = emp;
    i_Ready    = rdy;
    i_Mem_Data = m_inf ? seq : 8'($urandom);
    #1;
    if (rst) begin
      m_q.delete();
      m_inf = 1'b0;
    end
    e_pop = !rst && m_q.size() > 0 && rdy;
    e_en  = !rst && ((m_q.size() + int'(m_inf) < 2) || e_pop);
    chk("valid", o_Valid, m_q.size() > 0);
    chk("level", o_Level, m_q.size());
    chk("rd_en", o_RD_En, e_en);
    chk("err", o_Err, 0);
    if (rst) chk("rst data", o_Data, 0);
    else if (m_q.size() > 0) chk("data", o_Data, m_q[0]);
    if (o_Valid && rdy) begin
      got_w.push_back(o_Data);
      got_c.push_back(cyc);
    end
    if (!rst) begin
      if (e_pop) void'(m_q.pop_front());
      if (m_inf) begin
        if (m_q.size() < 2) m_q.push_back(seq);
        seq++;
      end
      m_inf = e_en && !emp;
    end
    cyc++;
  endtask

  typedef struct {
    bit         emp;
    bit         rdy;
    logic [7:0] mem;
    bit         v;
    logic [1:0] lvl;
    bit         en;
    logic [7:0] d;
  } vec_t;

  vec_t tv[13];

  initial begin
    i_RD_rst   = 1'b1;
    i_Empty    = 1'b1;
    i_Ready    = 1'b0;
    i_Mem_Data = 8'h00;

    tv[0]  = '{1, 0, 8'h5A, 0, 2'd0, 1, 8'h00};
    tv[1]  = '{0, 0, 8'h5A, 0, 2'd0, 1, 8'h00};
    tv[2]  = '{1, 0, 8'hA5, 0, 2'd0, 1, 8'h00};
    tv[3]  = '{1, 1, 8'h00, 1, 2'd1, 1, 8'hA5};
    tv[4]  = '{1, 0, 8'h5A, 0, 2'd0, 1, 8'h00};
    tv[5]  = '{0, 0, 8'h5A, 0, 2'd0, 1, 8'h00};
    tv[6]  = '{0, 0, 8'hB1, 0, 2'd0, 1, 8'h00};
    tv[7]  = '{0, 0, 8'hB2, 1, 2'd1, 0, 8'hB1};
    tv[8]  = '{0, 0, 8'hCC, 1, 2'd2, 0, 8'hB1};
    tv[9]  = '{0, 0, 8'hCC, 1, 2'd2, 0, 8'hB1};
    tv[10] = '{1, 1, 8'h5A, 1, 2'd2, 1, 8'hB1};
    tv[11] = '{1, 1, 8'h5A, 1, 2'd1, 1, 8'hB2};
    tv[12] = '{1, 0, 8'h5A, 0, 2'd0, 1, 8'h00};

    @(negedge clk);
    #1;
    chk("reset valid", o_Valid, 0);
    chk("reset data", o_Data, 0);
    chk("reset level", o_Level, 0);
    chk("reset rd_en", o_RD_En, 0);
    chk("reset err", o_Err, 0);

    // single word, then backpressure filling both entries
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      i_RD_rst   = 1'b0;
      i_Empty    = tv[i].emp;
      i_Ready    = tv[i].rdy;
      i_Mem_Data = tv[i].mem;
      #1;
      chk($sformatf("vec%0d valid", i), o_Valid, tv[i].v);
      chk($sformatf("vec%0d level", i), o_Level, tv[i].lvl);
      chk($sformatf("vec%0d rd_en", i), o_RD_En, tv[i].en);
      if (tv[i].v) chk($sformatf("vec%0d data", i), o_Data, tv[i].d);
    end

    // fill to TWO, then inject an arrival with no room
    @(negedge clk); i_Empty = 1'b0; i_Ready = 1'b0; i_Mem_Data = 8'h5A;
    @(negedge clk); i_Mem_Data = 8'hC1;
    @(negedge clk); i_Empty = 1'b1; i_Mem_Data = 8'hC2;
    @(negedge clk); i_Mem_Data = 8'hEE;
    #1;
    chk("ovf pre level", o_Level, 2);
    chk("ovf pre err", o_Err, 0);
    chk("ovf pre rd_en", o_RD_En, 0);
    force dut.r_Inflight = 1'b1;
    @(negedge clk);
    release dut.r_Inflight;
    #1;
    chk("ovf err", o_Err, 1);
    chk("ovf level", o_Level, 2);
    chk("ovf data", o_Data, 8'hC1);
    @(negedge clk);
    #1;
    chk("ovf err sticky", o_Err, 1);
    chk("ovf data hold", o_Data, 8'hC1);

    // async reset at Level 2, checked before any edge
    i_RD_rst = 1'b1;
    #1;
    chk("midrst valid", o_Valid, 0);
    chk("midrst data", o_Data, 0);
    chk("midrst level", o_Level, 0);
    chk("midrst rd_en", o_RD_En, 0);
    chk("midrst err", o_Err, 0);

    // streaming 0x01..0x10 with consumer always ready
    step(1, 1, 0);
    seq = 8'h01; cyc = 0;
    got_w.delete(); got_c.delete();
    for (int i = 0; i < 16; i++) step(0, 0, 1);
    for (int i = 0; i < 6; i++) step(0, 1, 1);
    chk("stream count", got_w.size(), 16);
    if (got_w.size() == 16) begin
      for (int i = 0; i < 16; i++)
        chk($sformatf("stream word%0d", i), got_w[i], i + 1);
      chk("stream first cycle", got_c[0], 2);
      chk("stream span", got_c[15] - got_c[0], 15);
    end

    // source runs empty after three fetches
    step(1, 1, 0);
    seq = 8'h40; cyc = 0;
    got_w.delete(); got_c.delete();
    for (int i = 0; i < 3; i++) step(0, 0, 1);
    for (int i = 0; i < 8; i++) step(0, 1, 1);
    chk("drain count", got_w.size(), 3);
    chk("drain valid", o_Valid, 0);
    chk("drain rd_en", o_RD_En, 1);

    // random traffic with occasional resets
    step(1, 1, 0);
    seq = 8'h00;
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) != 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
